store_buffer: RTL and testbench

Posted-write buffer between the processor's data-memory port and data memory. Stores are accepted into a DEPTH-entry in-order FIFO and retire to memory when the memory port is free. Loads take priority over draining. Loads that hit a buffered store are forwarded, or stalled in the reduced build. A `mem_ready` handshake lets the same block front the zero-wait-state data memory (`mem_ready` tied 1) or a slower memory.

---
 rtl/store_buffer.sv | 97 +++++++++
 tb/tb_store_buffer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the CPU data port and data memory; loads take the port first.
// Define STORE_BUFFER_FORWARD_EN to forward loads that hit a buffered store instead of stalling them.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_we,
    input  logic        cpu_re,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [29:0]   addr_q [DEPTH];
    logic [29:0]   addr_d [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [31:0]   data_d [DEPTH];
    logic [AW-1:0] head_q, head_d, tail_q, tail_d, idx;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   fwd_data;
    logic          hit, full, load_mem, drain, push, pop;

    assign full  = count_q == CW'(DEPTH);
    assign empty = count_q == '0;

    // Scan oldest to youngest so the last match seen is the youngest store.
    always_comb begin
        hit = 1'b0;
        fwd_data = '0;
        idx = head_q;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + AW'(k);
            if (CW'(k) < count_q && addr_q[idx] == cpu_addr[31:2]) begin
                hit = 1'b1;
                fwd_data = data_q[idx];
            end
        end
    end

    assign load_mem  = !reset && cpu_re && !hit;
    assign drain     = !reset && !load_mem && !empty;
    assign push      = !reset && cpu_we && !cpu_re && !full;
    assign pop       = drain && mem_ready;
    assign mem_req   = load_mem || drain;
    assign mem_we    = drain;
    assign mem_addr  = load_mem ? {cpu_addr[31:2], 2'b00} : drain ? {addr_q[head_q], 2'b00} : '0;
    assign mem_wdata = drain ? data_q[head_q] : '0;

`ifdef STORE_BUFFER_FORWARD_EN
    logic unused_bits;
    assign unused_bits = ^cpu_addr[1:0];
    assign cpu_rdata   = (cpu_re && hit) ? fwd_data : mem_rdata;
    assign stall       = !reset && (cpu_re ? (!hit && !mem_ready) : (cpu_we && full));
`else
    logic unused_bits;
    assign unused_bits = ^{cpu_addr[1:0], fwd_data};
    assign cpu_rdata   = mem_rdata;
    assign stall       = !reset && (cpu_re ? (hit || !mem_ready) : (cpu_we && full));
`endif

    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        head_d  = head_q + AW'(pop);
        tail_d  = tail_q + AW'(push);
        count_d = count_q + CW'(push) - CW'(pop);
        if (push) begin
            addr_d[tail_q] = cpu_addr[31:2];
            data_d[tail_q] = cpu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: table-driven directed vectors plus a full-buffer/drain-order sequence for store_buffer.
module tb_store_buffer;
    localparam logic [31:0] MR = 32'h5A5A_0F0F;
`ifdef STORE_BUFFER_FORWARD_EN
    localparam logic FWD = 1'b1;
`else
    localparam logic FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, cpu_we, cpu_re, mem_ready;
    logic [31:0] cpu_addr, cpu_wdata, mem_rdata;
    logic [31:0] cpu_rdata, mem_addr, mem_wdata;
    logic        stall, mem_req, mem_we, empty;
    int          n_tests = 0;
    int          n_fail = 0;

    store_buffer #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset), .cpu_we(cpu_we), .cpu_re(cpu_re),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, we, re, rdy;
        logic [31:0] addr, wdata;
        logic        e_stall, e_req, e_we, e_empty;
        logic [31:0] e_addr, e_wdata, e_rdata;
    } vec_t;

    vec_t tbl [34];

    function automatic vec_t v(input logic rst, we, re, input logic [31:0] addr, wdata, input logic rdy,
                               input logic e_stall, e_req, e_we, input logic [31:0] e_addr, e_wdata,
                               input logic e_empty, input logic [31:0] e_rdata);
        vec_t t;
        t.rst = rst; t.we = we; t.re = re; t.addr = addr; t.wdata = wdata; t.rdy = rdy;
        t.e_stall = e_stall; t.e_req = e_req; t.e_we = e_we; t.e_addr = e_addr;
        t.e_wdata = e_wdata; t.e_empty = e_empty; t.e_rdata = e_rdata;
        return t;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, w, rd, input logic [31:0] a, d, input logic rdy);
        @(negedge clk);
        reset = r; cpu_we = w; cpu_re = rd; cpu_addr = a; cpu_wdata = d; mem_ready = rdy;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n_wr;
        mem_rdata = MR;
        reset = 1'b1; cpu_we = 1'b0; cpu_re = 1'b0; cpu_addr = '0; cpu_wdata = '0; mem_ready = 1'b1;
        tbl[0]  = v(1,1,1,'h08,'h99,1,        0,0,0,0,0,1,MR);
        tbl[1]  = v(0,1,0,'h13,'hAABBCCDD,1,  0,0,0,0,0,1,MR);
        tbl[2]  = v(0,0,0,0,0,1,              0,1,1,'h10,'hAABBCCDD,0,MR);
        tbl[3]  = v(0,0,0,0,0,1,              0,0,0,0,0,1,MR);
        tbl[4]  = v(0,1,0,'h00,'hA0,0,        0,0,0,0,0,1,MR);
        tbl[5]  = v(0,1,0,'h04,'hA4,0,        0,1,1,'h00,'hA0,0,MR);
        tbl[6]  = v(0,1,0,'h08,'hA8,0,        0,1,1,'h00,'hA0,0,MR);
        tbl[7]  = v(0,1,0,'h0C,'hAC,0,        0,1,1,'h00,'hA0,0,MR);
        tbl[8]  = v(0,1,0,'h20,'hB0,0,        1,1,1,'h00,'hA0,0,MR);
        tbl[9]  = v(0,1,0,'h20,'hB0,1,        1,1,1,'h00,'hA0,0,MR);
        tbl[10] = v(0,1,0,'h20,'hB0,1,        0,1,1,'h04,'hA4,0,MR);
        tbl[11] = v(0,0,0,0,0,1,              0,1,1,'h08,'hA8,0,MR);
        tbl[12] = v(0,0,0,0,0,1,              0,1,1,'h0C,'hAC,0,MR);
        tbl[13] = v(0,0,0,0,0,1,              0,1,1,'h20,'hB0,0,MR);
        tbl[14] = v(0,0,0,0,0,1,              0,0,0,0,0,1,MR);
        tbl[15] = v(0,1,0,'h40,1,0,           0,0,0,0,0,1,MR);
        tbl[16] = v(0,1,0,'h40,2,0,           0,1,1,'h40,1,0,MR);
        tbl[17] = v(0,0,1,'h40,0,0,           !FWD,1,1,'h40,1,0,FWD ? 32'd2 : MR);
        tbl[18] = v(0,0,1,'h40,0,1,           !FWD,1,1,'h40,1,0,FWD ? 32'd2 : MR);
        tbl[19] = v(0,0,1,'h40,0,1,           !FWD,1,1,'h40,2,0,FWD ? 32'd2 : MR);
        tbl[20] = v(0,0,1,'h40,0,1,           0,1,0,'h40,0,1,MR);
        tbl[21] = v(0,0,1,'h46,0,0,           1,1,0,'h44,0,1,MR);
        tbl[22] = v(0,1,0,'h50,5,1,           0,0,0,0,0,1,MR);
        tbl[23] = v(0,0,1,'h60,0,1,           0,1,0,'h60,0,0,MR);
        tbl[24] = v(0,0,1,'h64,0,1,           0,1,0,'h64,0,0,MR);
        tbl[25] = v(0,0,0,0,0,1,              0,1,1,'h50,5,0,MR);
        tbl[26] = v(0,0,0,0,0,1,              0,0,0,0,0,1,MR);
        tbl[27] = v(0,1,1,'h08,'h99,1,        0,1,0,'h08,0,1,MR);
        tbl[28] = v(0,0,0,0,0,1,              0,0,0,0,0,1,MR);
        tbl[29] = v(0,1,0,'h70,1,0,           0,0,0,0,0,1,MR);
        tbl[30] = v(0,1,0,'h74,2,0,           0,1,1,'h70,1,0,MR);
        tbl[31] = v(0,1,0,'h78,3,0,           0,1,1,'h70,1,0,MR);
        tbl[32] = v(1,0,0,0,0,1,              0,0,0,0,0,0,MR);
        tbl[33] = v(0,0,0,0,0,1,              0,0,0,0,0,1,MR);

        drive(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 34; i++) begin
            drive(tbl[i].rst, tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].wdata, tbl[i].rdy);
            check($sformatf("v%0d stall", i), {31'b0, stall}, {31'b0, tbl[i].e_stall});
            check($sformatf("v%0d mem_req", i), {31'b0, mem_req}, {31'b0, tbl[i].e_req});
            check($sformatf("v%0d mem_we", i), {31'b0, mem_we}, {31'b0, tbl[i].e_we});
            check($sformatf("v%0d mem_addr", i), mem_addr, tbl[i].e_addr);
            check($sformatf("v%0d mem_wdata", i), mem_wdata, tbl[i].e_wdata);
            check($sformatf("v%0d empty", i), {31'b0, empty}, {31'b0, tbl[i].e_empty});
            check($sformatf("v%0d cpu_rdata", i), cpu_rdata, tbl[i].e_rdata);
        end

        // Fill with memory busy, then a load while full still proceeds and a store stalls.
        for (int i = 0; i < 4; i++) drive(0, 1, 0, 32'h100 + 32'(4 * i), 32'h10 + 32'(i), 0);
        drive(0, 1, 0, 32'h200, 32'hEE, 0);
        check("full store stall", {31'b0, stall}, 32'd1);
        drive(0, 0, 1, 32'h300, 0, 1);
        check("full load stall", {31'b0, stall}, 32'd0);
        check("full load mem_we", {31'b0, mem_we}, 32'd0);
        check("full load mem_addr", mem_addr, 32'h300);
        n_wr = 0;
        for (int c = 0; c < 10; c++) begin
            drive(0, 0, 0, 0, 0, 1);
            if (empty) break;
            if (mem_req && mem_we) begin
                check($sformatf("drain%0d addr", n_wr), mem_addr, 32'h100 + 32'(4 * n_wr));
                check($sformatf("drain%0d data", n_wr), mem_wdata, 32'h10 + 32'(n_wr));
                n_wr++;
            end
        end
        check("drain write count", 32'(n_wr), 32'd4);
        check("drain final empty", {31'b0, empty}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
